router_rd_arb: RTL and testbench
================================

Name: router_rd_arb

Overview:
- Read-side scheduler for the router's three output FIFOs.
- Shares one 8-bit downstream port between FIFO 0/1/2 using packet-granular round-robin.
- Once a FIFO is granted, it keeps the port until its whole packet (header, payload, parity) has drained.
- Sits between the three router FIFOs and a single consumer with a valid/ready handshake.

Parameters:
- DW, 8, data byte width; FIFO lanes are DW+1 wide, bit DW is the header flag.
- TIMEOUT_CYC, 30, stall-cycle limit used only when ROUTER_RD_ARB_TIMEOUT_EN is defined.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- fifo_empty  in  3  per-FIFO empty flag, bit i = FIFO i.
- fifo_data  in  3*(DW+1)  lanes {fifo2,fifo1,fifo0}; data is valid on the cycle after that FIFO's read_enb.
- read_enb  out  3  one-hot FIFO read strobe.
- soft_reset  out  3  one-cycle FIFO flush pulse (optional feature only, otherwise constant 0).
- port_ready  in  1  consumer accepts port_data this cycle.
- port_valid  out  1  port_data holds a byte.
- port_data  out  DW  output byte.
- port_sof  out  1  qualifies the header byte (with port_valid).
- port_eof  out  1  qualifies the parity byte (with port_valid).
- grant  out  2  index of the granted FIFO; 3 = none.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous, resetn=0):
  - Outputs: read_enb=0, soft_reset=0, port_valid=0, port_sof=0, port_eof=0, port_data=0, grant=3, busy=0.
  - Internal: state=IDLE, round-robin pointer=0, byte counter=0, in-flight flag=0.
  - Reset mid-packet discards the packet; FIFO contents are untouched.
- States: IDLE, HDR, BODY, LAST.
- IDLE:
  - Pick the first non-empty FIFO, searching from the pointer upward modulo 3.
  - Next cycle: grant = that FIFO, state HDR.
  - All empty: stay in IDLE.
- Read issue rule (HDR/BODY/LAST):
  - read_enb[grant]=1 when all hold: the granted FIFO is not empty, no read is in flight, (port_valid=0 or port_ready=1), and bytes remain.
  - At most one read in flight, so peak throughput is 1 byte per 2 cycles.
- Data load:
  - The cycle after a read, the byte is loaded into port_data, with port_valid=1 on the following cycle.
  - port_valid stays high until port_ready=1.
  - Data, sof and eof hold stable while port_valid=1 and port_ready=0.
- HDR:
  - The first byte read must carry header flag = 1; it is output with port_sof=1.
  - Payload length L = header[DW-1:2], range 0..63.
  - Counter loads L; go to BODY if L>0, otherwise LAST.
- BODY:
  - Each read decrements the counter; at 0, go to LAST.
- LAST:
  - Read the parity byte and output it with port_eof=1.
  - When the consumer accepts it: pointer = grant+1 mod 3, grant=3, state IDLE.
- Header-flag check: a lane header flag of 0 in HDR, or 1 in BODY/LAST, is forwarded unchanged. The block does not check it.
- FIFO empty mid-packet: no read is issued and the state holds. This is a stall, not an error.
- Simultaneous requests: the round-robin order guarantees that each FIFO waits at most two packets.
- A port_ready=1 on the same cycle as a read issue is legal (pipelined).

Optional Feature:
- Macro: ROUTER_RD_ARB_TIMEOUT_EN.
- Defined:
  - A stall counter counts consecutive cycles with busy=1 and no byte accepted by the consumer.
  - When it reaches TIMEOUT_CYC: pulse soft_reset[grant] for 1 cycle, clear port_valid, advance the pointer, and return to IDLE.
  - The stall counter clears on any consumer acceptance and on reset.
- Undefined:
  - No stall counter is built; soft_reset is tied to 0.
  - The block waits indefinitely.

Decomposition:
- router_pkg holds:
  - State encoding: IDLE=2'd0, HDR=2'd1, BODY=2'd2, LAST=2'd3.
  - GRANT_NONE=2'd3.
  - The length field position.
  - The default TIMEOUT_CYC value.
- Sub-module router_rr_pick: combinational round-robin picker. Inputs: 3-bit request vector and 2-bit pointer. Outputs: 2-bit index and a found flag.

Test Plan:
1. Single packet: FIFO0 holds header 0x0C (L=3), payload 0x11 0x22 0x33, parity 0x1C, port_ready=1 → port emits 0x0C(sof), 0x11, 0x22, 0x33, 0x1C(eof); grant=0 throughout; returns to IDLE, then grant=3.
2. Round-robin: all three FIFOs hold a 2-byte packet (L=0), pointer=0 → grants in order 0, 1, 2; a second packet waiting in FIFO0 is served after FIFO2.
3. Back-pressure: port_ready held 0 for 5 cycles mid-payload → port_data/port_valid held stable, no read_enb, no byte lost; resumes when port_ready=1.
4. Empty stall: FIFO1 goes empty after its header → state stays BODY, read_enb=0; the packet completes correctly once data reappears.
5. Asynchronous reset in BODY with port_valid=1 → all outputs reach their reset values immediately; the next packet starts from FIFO0.
6. Timeout (macro defined): port_ready=0 for 30 cycles with grant=2 → soft_reset=3'b100 for exactly 1 cycle, port_valid=0, state IDLE, pointer=0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the router read-side arbiter: state encoding,
// grant sentinel, header length field position and round-robin helper.
package router_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2,
        LAST = 2'd3
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'd3;

    // Payload length lives in header[DW-1:LEN_LSB].
    localparam int LEN_LSB = 2;

    localparam int TIMEOUT_CYC_DEF = 30;

    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p >= 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/router_rd_arb_if.sv
// Downstream byte port of the router read arbiter (valid/ready handshake
// with start/end-of-packet qualifiers).
interface router_rd_arb_if #(parameter int DW = 8);

    logic          port_valid;
    logic          port_ready;
    logic [DW-1:0] port_data;
    logic          port_sof;
    logic          port_eof;

    modport master (
        output port_valid,
        output port_data,
        output port_sof,
        output port_eof,
        input  port_ready
    );

    modport slave (
        input  port_valid,
        input  port_data,
        input  port_sof,
        input  port_eof,
        output port_ready
    );

endinterface

// File: rtl/router_rr_pick.sv
// Combinational round-robin picker over three requesters, searching upward
// from the pointer modulo 3.
module router_rr_pick
    import router_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] idx,
    output logic       found
);

    logic [1:0] c0;
    logic [1:0] c1;
    logic [1:0] c2;

    always_comb begin
        c0    = (ptr == GRANT_NONE) ? 2'd0 : ptr;
        c1    = rr_next(c0);
        c2    = rr_next(c1);
        idx   = 2'd0;
        found = 1'b0;
        if (req[c0]) begin
            idx   = c0;
            found = 1'b1;
        end else if (req[c1]) begin
            idx   = c1;
            found = 1'b1;
        end else if (req[c2]) begin
            idx   = c2;
            found = 1'b1;
        end
    end

endmodule

// File: rtl/router_rd_arb.sv
// Packet-granular round-robin read scheduler for the three router FIFOs.
// Optional stall timeout with FIFO flush: define ROUTER_RD_ARB_TIMEOUT_EN.
module router_rd_arb
    import router_pkg::*;
#(
    parameter int DW = 8
`ifdef ROUTER_RD_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [2:0]          fifo_empty,
    input  logic [3*(DW+1)-1:0] fifo_data,
    output logic [2:0]          read_enb,
    output logic [2:0]          soft_reset,
    output logic [1:0]          grant,
    output logic                busy,
    router_rd_arb_if.master     port
);

    localparam int LW = DW + 1;
    localparam int CW = DW - LEN_LSB;

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          inflight_q, inflight_d;
    logic          valid_q, valid_d;
    logic          sof_q, sof_d;
    logic          eof_q, eof_d;
    logic [DW-1:0] data_q, data_d;

    logic [LW-1:0] lane;
    logic [CW-1:0] hdr_len;
    logic          gnt_empty;
    logic          accept;
    logic          bytes_left;
    logic          can_issue;
    logic [2:0]    req;
    logic [1:0]    pick_idx;
    logic          pick_found;
    logic          unused_hdr_flag;

`ifdef ROUTER_RD_ARB_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYC + 1);
    logic [SW-1:0] stall_q, stall_d;
    logic [2:0]    soft_q, soft_d;
    logic          stall_timeout;

    assign stall_timeout = (state_q != IDLE) && !accept && (stall_q == SW'(TIMEOUT_CYC - 1));
    // A FIFO being flushed this cycle must not be re-granted off stale data.
    assign req           = ~fifo_empty & ~soft_q;
    assign soft_reset    = soft_q;
`else
    assign req           = ~fifo_empty;
    assign soft_reset    = 3'b000;
`endif

    router_rr_pick u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        lane      = '0;
        gnt_empty = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (grant_q == 2'(i)) begin
                lane      = fifo_data[i*LW +: LW];
                gnt_empty = fifo_empty[i];
            end
        end
    end

    // The lane header flag is forwarded as-is and never inspected.
    assign unused_hdr_flag = lane[DW];
    assign hdr_len         = lane[DW-1:LEN_LSB];
    assign accept          = valid_q & port.port_ready;
    assign bytes_left      = (state_q == HDR) || (cnt_q != '0);
    assign can_issue       = (state_q != IDLE) && !gnt_empty && !inflight_q &&
                             (!valid_q || port.port_ready) && bytes_left;

    always_comb begin
        read_enb = 3'b000;
        for (int i = 0; i < 3; i++) begin
            read_enb[i] = can_issue && (grant_q == 2'(i));
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        inflight_d = can_issue;
        valid_d    = valid_q;
        data_d     = data_q;
        sof_d      = sof_q;
        eof_d      = eof_q;

        if (accept) begin
            valid_d = 1'b0;
        end
        if (can_issue && (state_q != HDR)) begin
            cnt_d = cnt_q - CW'(1);
        end
        if (inflight_q) begin
            valid_d = 1'b1;
            data_d  = lane[DW-1:0];
            sof_d   = (state_q == HDR);
            eof_d   = (state_q == LAST);
        end

        // In LAST the counter is reused as a one-shot "parity still to read".
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (inflight_q) begin
                    if (hdr_len != '0) begin
                        cnt_d   = hdr_len;
                        state_d = BODY;
                    end else begin
                        cnt_d   = CW'(1);
                        state_d = LAST;
                    end
                end
            end
            BODY: begin
                if (inflight_q && (cnt_q == '0)) begin
                    cnt_d   = CW'(1);
                    state_d = LAST;
                end
            end
            LAST: begin
                if (!inflight_q && accept && eof_q) begin
                    state_d = IDLE;
                    grant_d = GRANT_NONE;
                    ptr_d   = rr_next(grant_q);
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef ROUTER_RD_ARB_TIMEOUT_EN
        stall_d = ((state_q == IDLE) || accept) ? '0 : stall_q + SW'(1);
        soft_d  = 3'b000;
        if (stall_timeout) begin
            soft_d     = 3'b001 << grant_q;
            valid_d    = 1'b0;
            sof_d      = 1'b0;
            eof_d      = 1'b0;
            inflight_d = 1'b0;
            state_d    = IDLE;
            grant_d    = GRANT_NONE;
            ptr_d      = rr_next(grant_q);
            cnt_d      = '0;
            stall_d    = '0;
        end
`endif
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            grant_q    <= GRANT_NONE;
            ptr_q      <= 2'd0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
`ifdef ROUTER_RD_ARB_TIMEOUT_EN
            stall_q    <= '0;
            soft_q     <= 3'b000;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            sof_q      <= sof_d;
            eof_q      <= eof_d;
`ifdef ROUTER_RD_ARB_TIMEOUT_EN
            stall_q    <= stall_d;
            soft_q     <= soft_d;
`endif
        end
    end

    assign grant           = grant_q;
    assign busy            = (state_q != IDLE);
    assign port.port_valid = valid_q;
    assign port.port_data  = data_q;
    assign port.port_sof   = sof_q;
    assign port.port_eof   = eof_q;

endmodule

// File: tb/tb_router_rd_arb.sv
// Directed bench for router_rd_arb: FIFO models, consumer monitor and one
// task per scenario; timeout scenario built with ROUTER_RD_ARB_TIMEOUT_EN.
module tb_router_rd_arb;

    logic        clock = 1'b0;
    logic        resetn;
    logic [2:0]  fifo_empty;
    logic [26:0] fifo_data;
    logic [2:0]  read_enb;
    logic [2:0]  soft_reset;
    logic [1:0]  grant;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    router_rd_arb_if #(.DW(8)) port_if ();

    router_rd_arb #(.DW(8)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .read_enb   (read_enb),
        .soft_reset (soft_reset),
        .grant      (grant),
        .busy       (busy),
        .port       (port_if)
    );

    always #5 clock = ~clock;

    // FIFO models: synchronous read, data valid the cycle after read_enb.
    logic [8:0] mem [3][64];
    int         wr_p [3] = '{0, 0, 0};
    int         rd_p [3] = '{0, 0, 0};
    logic [8:0] lane_q [3] = '{9'h0, 9'h0, 9'h0};

    assign fifo_empty = {rd_p[2] == wr_p[2], rd_p[1] == wr_p[1], rd_p[0] == wr_p[0]};
    assign fifo_data  = {lane_q[2], lane_q[1], lane_q[0]};

    always @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (soft_reset[i]) begin
                rd_p[i] <= wr_p[i];
            end else if (read_enb[i] && (rd_p[i] != wr_p[i])) begin
                lane_q[i] <= mem[i][rd_p[i] % 64];
                rd_p[i]   <= rd_p[i] + 1;
            end
        end
    end

    // Accepted bytes as {grant, sof, eof, data}.
    logic [11:0] acc [$];

    always @(posedge clock) begin
        if (port_if.port_valid && port_if.port_ready) begin
            acc.push_back({grant, port_if.port_sof, port_if.port_eof, port_if.port_data});
        end
    end

    task automatic push(input int f, input logic [8:0] b);
        mem[f][wr_p[f] % 64] = b;
        wr_p[f] = wr_p[f] + 1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        port_if.port_ready = 1'b0;
        repeat (2) @(negedge clock);
        acc.delete();
        resetn = 1'b1;
    endtask

    task automatic wait_acc(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clock);
            if (acc.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [11:0] acc_at(input int k);
        return (k < acc.size()) ? acc[k] : 12'hFFF;
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        port_if.port_ready = 1'b0;
        @(negedge clock);
        n_checks++;
        if (grant !== 2'd3) begin
            n_fail++;
            $display("[TB] FAIL reset_grant: got %0d expected 3", grant);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
        n_checks++;
        if ({port_if.port_valid, port_if.port_sof, port_if.port_eof} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got %b expected 000",
                     {port_if.port_valid, port_if.port_sof, port_if.port_eof});
        end
        n_checks++;
        if (port_if.port_data !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL reset_data: got %h expected 00", port_if.port_data);
        end
        n_checks++;
        if ({read_enb, soft_reset} !== 6'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_strobes: got %b expected 000000", {read_enb, soft_reset});
        end
        resetn = 1'b1;
    endtask

    task automatic test_single_packet();
        logic [11:0] exp [5];
        int bad;
        bit ok;
        exp = '{{2'd0, 1'b1, 1'b0, 8'h0C}, {2'd0, 2'b00, 8'h11}, {2'd0, 2'b00, 8'h22},
                {2'd0, 2'b00, 8'h33}, {2'd0, 1'b0, 1'b1, 8'h1C}};
        do_reset();
        push(0, 9'h10C); push(0, 9'h011); push(0, 9'h022); push(0, 9'h033); push(0, 9'h01C);
        port_if.port_ready = 1'b1;
        bad = 0;
        ok  = 1'b0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge clock);
            if (busy && (grant !== 2'd0)) bad++;
            if (acc.size() >= 5) ok = 1'b1;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL single_done: got %0d bytes expected 5", acc.size());
        end
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (acc_at(k) !== exp[k]) begin
                n_fail++;
                $display("[TB] FAIL single_byte%0d: got %h expected %h", k, acc_at(k), exp[k]);
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("[TB] FAIL single_grant_hold: got %0d wrong-grant cycles expected 0", bad);
        end
        @(negedge clock);
        n_checks++;
        if ({grant, busy} !== {2'd3, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL single_idle: got grant=%0d busy=%b expected grant=3 busy=0", grant, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [11:0] exp [8];
        bit ok;
        exp = '{{2'd0, 1'b1, 1'b0, 8'h01}, {2'd0, 1'b0, 1'b1, 8'hA0},
                {2'd1, 1'b1, 1'b0, 8'h01}, {2'd1, 1'b0, 1'b1, 8'hB0},
                {2'd2, 1'b1, 1'b0, 8'h01}, {2'd2, 1'b0, 1'b1, 8'hC0},
                {2'd0, 1'b1, 1'b0, 8'h01}, {2'd0, 1'b0, 1'b1, 8'hA1}};
        do_reset();
        push(0, 9'h101); push(0, 9'h0A0); push(0, 9'h101); push(0, 9'h0A1);
        push(1, 9'h101); push(1, 9'h0B0);
        push(2, 9'h101); push(2, 9'h0C0);
        port_if.port_ready = 1'b1;
        wait_acc(8, 150, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL rr_done: got %0d bytes expected 8", acc.size());
        end
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (acc_at(k) !== exp[k]) begin
                n_fail++;
                $display("[TB] FAIL rr_byte%0d: got %h expected %h", k, acc_at(k), exp[k]);
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [11:0] exp [5];
        bit ok;
        exp = '{{2'd0, 1'b1, 1'b0, 8'h0C}, {2'd0, 2'b00, 8'h41}, {2'd0, 2'b00, 8'h42},
                {2'd0, 2'b00, 8'h43}, {2'd0, 1'b0, 1'b1, 8'h4F}};
        do_reset();
        push(0, 9'h10C); push(0, 9'h041); push(0, 9'h042); push(0, 9'h043); push(0, 9'h04F);
        port_if.port_ready = 1'b1;
        wait_acc(2, 40, ok);
        port_if.port_ready = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL bp_start: got %0d bytes expected 2", acc.size());
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (port_if.port_valid) break;
        end
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if ({port_if.port_valid, port_if.port_sof, port_if.port_eof, port_if.port_data, read_enb} !==
                {3'b100, 8'h42, 3'b000}) begin
                n_fail++;
                $display("[TB] FAIL bp_hold%0d: got valid=%b data=%h rd=%b expected valid=1 data=42 rd=000",
                         c, port_if.port_valid, port_if.port_data, read_enb);
            end
            @(negedge clock);
        end
        n_checks++;
        if (acc.size() != 2) begin
            n_fail++;
            $display("[TB] FAIL bp_no_accept: got %0d bytes expected 2", acc.size());
        end
        port_if.port_ready = 1'b1;
        wait_acc(5, 40, ok);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (acc_at(k) !== exp[k]) begin
                n_fail++;
                $display("[TB] FAIL bp_byte%0d: got %h expected %h", k, acc_at(k), exp[k]);
            end
        end
    endtask

    task automatic test_empty_stall();
        logic [11:0] exp [4];
        bit ok;
        exp = '{{2'd1, 1'b1, 1'b0, 8'h08}, {2'd1, 2'b00, 8'h55},
                {2'd1, 2'b00, 8'h66}, {2'd1, 1'b0, 1'b1, 8'h7A}};
        do_reset();
        push(1, 9'h108);
        port_if.port_ready = 1'b1;
        wait_acc(1, 30, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL stall_hdr: got %0d bytes expected 1", acc.size());
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            n_checks++;
            if ({read_enb, busy, grant} !== {3'b000, 1'b1, 2'd1}) begin
                n_fail++;
                $display("[TB] FAIL stall_hold%0d: got rd=%b busy=%b grant=%0d expected rd=000 busy=1 grant=1",
                         c, read_enb, busy, grant);
            end
        end
        push(1, 9'h055); push(1, 9'h066); push(1, 9'h07A);
        wait_acc(4, 40, ok);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (acc_at(k) !== exp[k]) begin
                n_fail++;
                $display("[TB] FAIL stall_byte%0d: got %h expected %h", k, acc_at(k), exp[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [11:0] exp [4];
        bit ok;
        exp = '{{2'd0, 1'b1, 1'b0, 8'h01}, {2'd0, 1'b0, 1'b1, 8'hE0},
                {2'd2, 1'b1, 1'b0, 8'h00}, {2'd2, 1'b0, 1'b1, 8'h9F}};
        do_reset();
        push(2, 9'h108); push(2, 9'h091); push(2, 9'h100); push(2, 9'h09F);
        port_if.port_ready = 1'b1;
        wait_acc(1, 30, ok);
        port_if.port_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (port_if.port_valid) break;
        end
        n_checks++;
        if ({port_if.port_valid, port_if.port_data, busy} !== {1'b1, 8'h91, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL arst_pre: got valid=%b data=%h busy=%b expected valid=1 data=91 busy=1",
                     port_if.port_valid, port_if.port_data, busy);
        end
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if ({port_if.port_valid, port_if.port_sof, port_if.port_eof, busy} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL arst_flags: got %b expected 0000",
                     {port_if.port_valid, port_if.port_sof, port_if.port_eof, busy});
        end
        n_checks++;
        if ({grant, port_if.port_data, read_enb} !== {2'd3, 8'h00, 3'b000}) begin
            n_fail++;
            $display("[TB] FAIL arst_values: got grant=%0d data=%h rd=%b expected grant=3 data=00 rd=000",
                     grant, port_if.port_data, read_enb);
        end
        @(negedge clock);
        acc.delete();
        resetn = 1'b1;
        push(0, 9'h101); push(0, 9'h0E0);
        port_if.port_ready = 1'b1;
        wait_acc(4, 60, ok);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (acc_at(k) !== exp[k]) begin
                n_fail++;
                $display("[TB] FAIL arst_byte%0d: got %h expected %h", k, acc_at(k), exp[k]);
            end
        end
    endtask

`ifdef ROUTER_RD_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int pulses;
        logic [2:0] pv;
        bit ok;
        do_reset();
        push(2, 9'h108); push(2, 9'h011); push(2, 9'h022); push(2, 9'h02F);
        pulses = 0;
        pv     = 3'b000;
        for (int c = 0; c < 80; c++) begin
            @(negedge clock);
            if (soft_reset !== 3'b000) begin
                pulses++;
                pv = soft_reset;
                n_checks++;
                if ({port_if.port_valid, busy, grant} !== {1'b0, 1'b0, 2'd3}) begin
                    n_fail++;
                    $display("[TB] FAIL to_state: got valid=%b busy=%b grant=%0d expected valid=0 busy=0 grant=3",
                             port_if.port_valid, busy, grant);
                end
            end
        end
        n_checks++;
        if ({pulses, pv} !== {32'd1, 3'b100}) begin
            n_fail++;
            $display("[TB] FAIL to_pulse: got %0d pulses value %b expected 1 pulse value 100", pulses, pv);
        end
        push(1, 9'h101); push(1, 9'h0D1);
        push(0, 9'h101); push(0, 9'h0D0);
        port_if.port_ready = 1'b1;
        wait_acc(4, 60, ok);
        n_checks++;
        if ({acc_at(0), acc_at(2)} !== {2'd0, 1'b1, 1'b0, 8'h01, 2'd1, 1'b1, 1'b0, 8'h01}) begin
            n_fail++;
            $display("[TB] FAIL to_pointer: got %h %h expected 201 601", acc_at(0), acc_at(2));
        end
    endtask
`endif

    initial begin
        resetn = 1'b0;
        port_if.port_ready = 1'b0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_back_pressure();
        test_empty_stall();
        test_async_reset();
`ifdef ROUTER_RD_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
